// File: rtl/mips_pkg.sv
// Shared data-memory definitions: responder FSM encodings and bus widths.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the responder (slave).
interface dmem_responder_if
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dmem_byte_merge.sv
// Byte-enable merge of store data into an existing word (combinational).
module dmem_byte_merge
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYC wait states, then a held response.
// Optional DMEM_RESP_RANGE_CHK_EN flags addresses >= DEPTH instead of wrapping them.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned WAIT_CYC = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WAIT_CYC > 15) begin : g_bad_wait
        $error("WAIT_CYC must be in 0..15");
    end
    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("DEPTH must not exceed 2**ADDR_W");
    end

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] merged;
    logic              access;
    logic              out_of_range;
    logic              unused_addr;

    assign idx         = addr_q[IDX_W-1:0];
    assign old_word    = mem[idx];
    assign access      = (state_q == StWait) && (cnt_q == '0);
    assign unused_addr = ^addr_q;

`ifdef DMEM_RESP_RANGE_CHK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    assign out_of_range = ({1'b0, addr_q} >= DEPTH_LIM);
`else
    assign out_of_range = 1'b0;
`endif

    dmem_byte_merge u_merge (
        .old_word (old_word),
        .wdata    (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d = StWait;
                    cnt_d   = CNT_W'(WAIT_CYC);
                end
            end
            // With cnt_q == 0 on entry this cycle is the access, giving latency WAIT_CYC+1.
            StWait: begin
                if (cnt_q == '0) state_d = StResp;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) begin
                rdata_q <= out_of_range ? '0 : (we_q ? merged : old_word);
                err_q   <= out_of_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StIdle && bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    // Storage is not reset; rst still blocks a store that would commit on this edge.
    always_ff @(posedge clk) begin
        if (!rst && access && we_q && !out_of_range) mem[idx] <= merged;
    end

    assign bus.req_ready = (state_q == StIdle) && !rst;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: DUT A (DEPTH 512, 2 wait states), DUT B (0 wait states).
module tb_dmem_responder;
    import mips_pkg::*;

    localparam int WA = 2;
    localparam int WB = 0;

`ifdef DMEM_RESP_RANGE_CHK_EN
    localparam logic [31:0] EXP_LD600 = 32'h0000_0000;
    localparam logic        EXP_ER600 = 1'b1;
    localparam logic [31:0] EXP_ST600 = 32'h0000_0000;
    localparam logic [31:0] EXP_LD88  = 32'hCAFE_F00D;
`else
    localparam logic [31:0] EXP_LD600 = 32'hCAFE_F00D;
    localparam logic        EXP_ER600 = 1'b0;
    localparam logic [31:0] EXP_ST600 = 32'h0BAD_C0DE;
    localparam logic [31:0] EXP_LD88  = 32'h0BAD_C0DE;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if #(.ADDR_W(10)) ifa ();
    dmem_responder_if #(.ADDR_W(10)) ifb ();

    dmem_responder #(.ADDR_W(10), .DEPTH(512), .WAIT_CYC(WA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dmem_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYC(WB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;
    bit   seen_a = 1'b0;
    bit   seen_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitors: every cycle a response is shown it must match the queue head.
    always @(negedge clk) begin
        if (ifa.rsp_valid === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_rsp: rsp_valid=1 rdata=%h, expected no response",
                         ifa.rsp_rdata);
            end else begin
                chk("a_rdata", ifa.rsp_rdata, qa[0].rdata);
                chk1("a_err", ifa.rsp_err, qa[0].err);
                chk1("a_req_ready_in_resp", ifa.req_ready, 1'b0);
                chk1("a_busy_in_resp", ifa.busy, 1'b1);
                if (!seen_a) chk("a_latency_cycle", cyc, qa[0].cyc);
                seen_a <= 1'b1;
                if (ifa.rsp_ready) begin
                    void'(qa.pop_front());
                    seen_a <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.rsp_valid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_rsp: rsp_valid=1 rdata=%h, expected no response",
                         ifb.rsp_rdata);
            end else begin
                chk("b_rdata", ifb.rsp_rdata, qb[0].rdata);
                chk1("b_err", ifb.rsp_err, qb[0].err);
                chk1("b_req_ready_in_resp", ifb.req_ready, 1'b0);
                if (!seen_b) chk("b_latency_cycle", cyc, qb[0].cyc);
                seen_b <= 1'b1;
                if (ifb.rsp_ready) begin
                    void'(qb.pop_front());
                    seen_b <= 1'b0;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input bit sel, input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        bit   got = 1'b0;
        exp_t e;
        if (sel) begin
            ifb.req_valid = 1'b1; ifb.req_we = we; ifb.req_addr = addr;
            ifb.req_wdata = wdata; ifb.req_be = be;
        end else begin
            ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_addr = addr;
            ifa.req_wdata = wdata; ifa.req_be = be;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((sel ? ifb.req_ready : ifa.req_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = cyc + (sel ? WB : WA) + 1;
            if (push) begin
                if (sel) qb.push_back(e);
                else     qa.push_back(e);
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: req_ready stayed 0, expected 1 within 50 cycles");
            @(posedge clk);
            #1;
        end
        if (sel) ifb.req_valid = 1'b0;
        else     ifa.req_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (qa.size() == 0 && qb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d/%0d responses pending, expected 0", qa.size(),
                     qb.size());
        end
    endtask

    task automatic check_reset_a(input string tag);
        chk1({tag, "_req_ready"}, ifa.req_ready, 1'b1);
        chk1({tag, "_rsp_valid"}, ifa.rsp_valid, 1'b0);
        chk({tag, "_rsp_rdata"}, ifa.rsp_rdata, 32'h0);
        chk1({tag, "_rsp_err"}, ifa.rsp_err, 1'b0);
        chk1({tag, "_busy"}, ifa.busy, 1'b0);
    endtask

    initial begin
        bit got;
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0;
        ifa.req_wdata = '0; ifa.req_be = '0; ifa.rsp_ready = 1'b1;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0;
        ifb.req_wdata = '0; ifb.req_be = '0; ifb.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_req_ready_low", ifa.req_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_a("por");
        chk1("por_b_busy", ifb.busy, 1'b0);
        @(posedge clk); #1;

        // Reset mid-WAIT must drop the pending store to addr 5.
        do_req(0, 1'b1, 10'd5, 32'h0A0A_0A0A, 4'hF, 32'h0A0A_0A0A, 1'b0, 1);
        drain();
        do_req(0, 1'b1, 10'd5, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_a("abort");
        @(posedge clk); #1;
        do_req(0, 1'b0, 10'd5, 32'h0, 4'h0, 32'h0A0A_0A0A, 1'b0, 1);
        drain();

        // Full store, partial store, empty-enable store, each read back.
        do_req(0, 1'b1, 10'd3, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 1'b0, 1);
        do_req(0, 1'b0, 10'd3, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1);
        do_req(0, 1'b1, 10'd3, 32'h1122_3344, 4'b0101, 32'hDE22_BE44, 1'b0, 1);
        do_req(0, 1'b1, 10'd3, 32'hFFFF_FFFF, 4'b0000, 32'hDE22_BE44, 1'b0, 1);
        do_req(0, 1'b0, 10'd3, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 1);
        drain();

        // Backpressure: response held while a new request waits outside.
        ifa.rsp_ready = 1'b0;
        do_req(0, 1'b0, 10'd3, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL bp_rsp_timeout: rsp_valid stayed 0, expected 1");
        end
        @(posedge clk); #1;
        ifa.req_valid = 1'b1; ifa.req_we = 1'b1; ifa.req_addr = 10'd7;
        ifa.req_wdata = 32'h1234_5678; ifa.req_be = 4'hF;
        repeat (5) begin
            @(negedge clk);
            chk1("bp_req_ready", ifa.req_ready, 1'b0);
            chk1("bp_rsp_valid", ifa.rsp_valid, 1'b1);
        end
        @(posedge clk); #1 ifa.rsp_ready = 1'b1;
        do_req(0, 1'b1, 10'd7, 32'h1234_5678, 4'hF, 32'h1234_5678, 1'b0, 1);
        do_req(0, 1'b0, 10'd7, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1);
        drain();

        // Address range / wrap on the 512-word instance.
        do_req(0, 1'b1, 10'd88, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 1'b0, 1);
        do_req(0, 1'b0, 10'd600, 32'h0, 4'h0, EXP_LD600, EXP_ER600, 1);
        do_req(0, 1'b1, 10'd600, 32'h0BAD_C0DE, 4'hF, EXP_ST600, EXP_ER600, 1);
        do_req(0, 1'b0, 10'd88, 32'h0, 4'h0, EXP_LD88, 1'b0, 1);
        drain();

        // Zero-wait instance: response one edge after accept.
        do_req(1, 1'b1, 10'd1, 32'h1357_2468, 4'hF, 32'h1357_2468, 1'b0, 1);
        do_req(1, 1'b0, 10'd1, 32'h0, 4'h0, 32'h1357_2468, 1'b0, 1);
        do_req(1, 1'b1, 10'd1, 32'hAABB_CCDD, 4'b1000, 32'hAA57_2468, 1'b0, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget, expected completion");
        $fatal(1, "timeout");
    end

endmodule
